lshifter_pipe: RTL and testbench

- Pipelined left barrel shifter. It is the left-direction counterpart of the team's combinational right shifter.
- Shifts `data_in` left by `bits` positions. Mode is either logical (zero fill) or rotate (wrap-around).
- There is one register stage per shift-amount bit, with valid/ready handshakes on both sides.
- Sits in the datapath wherever a registered, backpressure-aware left shift or rotate is needed at full clock rate.

---
 rtl/shifter_pkg.sv | 8 +
 rtl/lshift_stage.sv | 70 +++++++
 rtl/lshifter_pipe.sv | 60 ++++++
 tb/tb_lshifter_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared constants for the shifter family: default widths and the shift-mode encoding.
package shifter_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int SHIFT_LEN  = 3;

  localparam logic MODE_LSL = 1'b0;
  localparam logic MODE_ROL = 1'b1;
endpackage

// File: rtl/lshift_stage.sv
// One pipeline stage of the left barrel shifter: conditionally shifts by 2**stage_idx and
// registers data, valid, the not-yet-consumed shift-amount bits and the mode.
module lshift_stage
  import shifter_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int shift_len  = SHIFT_LEN,
  parameter int stage_idx  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  v_in,
  input  logic [data_width-1:0] data_in,
  input  logic [shift_len-1:0]  amt_in,
  input  logic                  mode_in,
  output logic                  v_out,
  output logic [data_width-1:0] data_out,
  output logic [shift_len-1:0]  amt_out,
  output logic                  mode_out
);
  localparam int SH = 1 << stage_idx;

  logic                  v_d, v_q;
  logic [data_width-1:0] data_d, data_q;
  logic [shift_len-1:0]  amt_d, amt_q;
  logic                  mode_d, mode_q;
  logic [data_width-1:0] shifted;

  // The amount is consumed LSB-first, so bit 0 is always this stage's decision bit.
  always_comb begin
    shifted = data_in;
    if (amt_in[0]) begin
      if (mode_in == MODE_ROL) shifted = (data_in << SH) | (data_in >> (data_width - SH));
      else                     shifted = data_in << SH;
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    amt_d  = amt_q;
    mode_d = mode_q;
    if (en) begin
      v_d    = v_in;
      data_d = shifted;
      amt_d  = amt_in >> 1;
      mode_d = mode_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
      amt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      amt_q  <= amt_d;
      mode_q <= mode_d;
    end
  end

  assign v_out    = v_q;
  assign data_out = data_q;
  assign amt_out  = amt_q;
  assign mode_out = mode_q;
endmodule

// File: rtl/lshifter_pipe.sv
// Pipelined left shift / rotate: one register stage per shift-amount bit, valid/ready on
// both sides with a single global stall driven by the last stage.
module lshifter_pipe
  import shifter_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int shift_len  = SHIFT_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] data_in,
  input  logic [shift_len-1:0]  bits,
  input  logic                  rotate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] data_out
);
  // Index 0 is the input port side; index k+1 is the output of stage k.
  logic [shift_len:0]                 v_p;
  logic [shift_len:0][data_width-1:0] data_p;
  logic [shift_len:0][shift_len-1:0]  amt_p;
  logic [shift_len:0]                 mode_p;
  logic                               en;
  logic                               unused_tail;

  assign en        = !v_p[shift_len] | out_ready;
  assign in_ready  = en;
  assign v_p[0]    = in_valid;
  assign data_p[0] = data_in;
  assign amt_p[0]  = bits;
  assign mode_p[0] = rotate;

  for (genvar k = 0; k < shift_len; k++) begin : g_stage
    lshift_stage #(
      .data_width(data_width),
      .shift_len (shift_len),
      .stage_idx (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .v_in    (v_p[k]),
      .data_in (data_p[k]),
      .amt_in  (amt_p[k]),
      .mode_in (mode_p[k]),
      .v_out   (v_p[k+1]),
      .data_out(data_p[k+1]),
      .amt_out (amt_p[k+1]),
      .mode_out(mode_p[k+1])
    );
  end

  // Amount and mode are fully consumed by the last stage.
  assign unused_tail = ^{amt_p[shift_len], mode_p[shift_len]};

  assign out_valid = v_p[shift_len];
  assign data_out  = data_p[shift_len];
endmodule

// File: tb/tb_lshifter_pipe.sv
// Scoreboard bench for lshifter_pipe: driver pushes model results on input transfer,
// monitor pops and compares on output transfer, plus stall-stability and reset checks.
module tb_lshifter_pipe;
  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] data_in = '0;
  logic [S-1:0] bits = '0;
  logic         rotate = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] data_out;

  lshifter_pipe #(.data_width(W), .shift_len(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .bits(bits), .rotate(rotate),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    int           cyc;
    bit           lat;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  bit    rnd_bp = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: each source bit i lands at position i+b (mod W for rotate, dropped otherwise).
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int b, input bit r);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < W; i++) begin
      if (r)              res[(i + b) % W] = d[i];
      else if (i + b < W) res[i + b] = d[i];
    end
    return res;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [S-1:0] b, input logic r,
                      input logic [W-1:0] exp, input bit lat, output int waits);
    item_t it;
    data_in  = d;
    bits     = b;
    rotate   = r;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      chk("send_timeout", waits, 0);
    end else begin
      it.exp = exp;
      it.cyc = cyc;
      it.lat = lat;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    data_in  = W'($urandom);
    bits     = S'($urandom);
    rotate   = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: output transfers against scoreboard, plus hold-while-stalled checks.
  initial begin
    item_t        it;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_hold", int'(out_valid), 1);
          chk("stall_data_hold", int'(data_out), int'(prev_data));
        end
        if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", int'(data_out), -1);
          end else begin
            it = q.pop_front();
            chk("data_out", int'(data_out), int'(it.exp));
            if (it.lat) chk("latency", cyc - it.cyc, S);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = data_out;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 3) != 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int waits;
    logic [W-1:0] d;
    logic [S-1:0] b;
    logic         r;

    // Reset state
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed shifts with spec-given results
    send(8'b1011_0011, 3'd3, 1'b0, 8'b1001_1000, 1'b1, waits);
    idle(4);
    send(8'b1011_0011, 3'd3, 1'b1, 8'b1001_1101, 1'b1, waits);
    send(8'h01, 3'd7, 1'b1, 8'h80, 1'b1, waits);
    send(8'hFF, 3'd7, 1'b0, 8'h80, 1'b1, waits);
    idle(1);
    drain();

    // Streaming: back-to-back, in_ready must never drop
    for (int i = 0; i < 8; i++) begin
      send(W'(i), S'(i), 1'(i & 1), ref_shift(W'(i), i, 1'(i & 1)), 1'b1, waits);
      chk("stream_in_ready", waits, 0);
    end
    idle(1);
    drain();

    // Pass-through, both modes
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom);
      send(d, '0, 1'(i & 1), d, 1'b1, waits);
    end
    idle(1);
    drain();

    // Backpressure: stall 4 cycles once the first result appears
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          d = W'($urandom);
          b = S'($urandom);
          r = 1'($urandom);
          send(d, b, r, ref_shift(d, int'(b), r), 1'b0, waits);
        end
        idle(1);
      end
      begin
        int n;
        n = 0;
        forever begin
          @(posedge clk);
          #1;
          n++;
          if (out_valid || n > 50) break;
        end
        chk("bp_first_seen", int'(out_valid), 1);
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight with 3 items in the pipe
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom);
      send(d, S'(i + 1), 1'b0, ref_shift(d, i + 1, 1'b0), 1'b0, waits);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle(6);
    send(8'hC5, 3'd2, 1'b1, 8'h17, 1'b1, waits);
    idle(1);
    drain();

    // Random traffic with random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      d = W'($urandom);
      b = S'($urandom);
      r = 1'($urandom);
      send(d, b, r, ref_shift(d, int'(b), r), 1'b0, waits);
    end
    idle(1);
    rnd_bp = 1'b0;
    #1;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
